// File: rtl/button_repeat.sv
// Hold-to-repeat step generator: one strobe on press, then repeat strobes while a single
// button stays held. Conflicting or pre-held presses are locked out until both buttons are low.
module button_repeat #(
    parameter int unsigned INITIAL_DELAY = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic sysclk,
    input  logic reset,
    input  logic Plus_deb,
    input  logic Minus_deb,
    output logic Plus_step,
    output logic Minus_step,
    output logic Holding
);

    typedef enum logic [1:0] {
        StWaitRel,
        StIdle,
        StDelay,
        StRepeat
    } state_t;

    localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(INITIAL_DELAY - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state;
    logic             dir;
    logic [CNT_W-1:0] cnt;

    logic held;
    logic other;
    logic at_last;

    always_comb begin
        held    = dir ? Plus_deb : Minus_deb;
        other   = dir ? Minus_deb : Plus_deb;
        at_last = (state == StDelay) ? (cnt == DelayLast) : (cnt == RepeatLast);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state      <= StWaitRel;
            dir        <= 1'b0;
            cnt        <= '0;
            Plus_step  <= 1'b0;
            Minus_step <= 1'b0;
            Holding    <= 1'b0;
        end else begin
            Plus_step  <= 1'b0;
            Minus_step <= 1'b0;
            case (state)
                StWaitRel: begin
                    if (!Plus_deb && !Minus_deb) begin
                        state <= StIdle;
                    end
                end
                StIdle: begin
                    if (Plus_deb != Minus_deb) begin
                        dir        <= Plus_deb;
                        Plus_step  <= Plus_deb;
                        Minus_step <= Minus_deb;
                        cnt        <= '0;
                        Holding    <= 1'b1;
                        state      <= StDelay;
                    end else if (Plus_deb) begin
                        state <= StWaitRel;
                    end
                end
                StDelay, StRepeat: begin
                    // Conflict outranks release, which outranks terminal count.
                    if (other) begin
                        Holding <= 1'b0;
                        state   <= StWaitRel;
                    end else if (!held) begin
                        Holding <= 1'b0;
                        state   <= StIdle;
                    end else if (at_last) begin
                        Plus_step  <= dir;
                        Minus_step <= ~dir;
                        cnt        <= '0;
                        state      <= StRepeat;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    Holding <= 1'b0;
                    state   <= StWaitRel;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_repeat.sv
// Randomized and directed bench for button_repeat, checked every cycle against a hold-age model.
module tb_button_repeat;

    localparam int ID = 8;
    localparam int RP = 4;

    logic sysclk = 1'b0;
    logic reset;
    logic Plus_deb;
    logic Minus_deb;
    logic Plus_step;
    logic Minus_step;
    logic Holding;

    button_repeat #(
        .INITIAL_DELAY(ID),
        .REPEAT_PERIOD(RP),
        .CNT_W(4)
    ) dut (
        .sysclk(sysclk),
        .reset(reset),
        .Plus_deb(Plus_deb),
        .Minus_deb(Minus_deb),
        .Plus_step(Plus_step),
        .Minus_step(Minus_step),
        .Holding(Holding)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int plus_q[$];
    int minus_q[$];
    int hold_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a hold is described by its button and its age in edges since the press.
    bit m_locked, m_holding, m_btn;
    int m_age;
    bit e_plus, e_minus, e_hold;

    function automatic bit repeat_due(input int age);
        return age >= ID && ((age - ID) % RP) == 0;
    endfunction

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_locked  <= 1'b1;
            m_holding <= 1'b0;
            m_btn     <= 1'b0;
            m_age     <= 0;
            e_plus    <= 1'b0;
            e_minus   <= 1'b0;
            e_hold    <= 1'b0;
        end else begin
            e_plus  <= 1'b0;
            e_minus <= 1'b0;
            if (m_locked) begin
                if (!Plus_deb && !Minus_deb) m_locked <= 1'b0;
            end else if (!m_holding) begin
                if (Plus_deb != Minus_deb) begin
                    m_holding <= 1'b1;
                    e_hold    <= 1'b1;
                    m_btn     <= Plus_deb;
                    m_age     <= 0;
                    e_plus    <= Plus_deb;
                    e_minus   <= Minus_deb;
                end else if (Plus_deb) begin
                    m_locked <= 1'b1;
                end
            end else if (m_btn ? Minus_deb : Plus_deb) begin
                m_holding <= 1'b0;
                e_hold    <= 1'b0;
                m_locked  <= 1'b1;
            end else if (!(m_btn ? Plus_deb : Minus_deb)) begin
                m_holding <= 1'b0;
                e_hold    <= 1'b0;
            end else begin
                m_age <= m_age + 1;
                if (repeat_due(m_age + 1)) begin
                    e_plus  <= m_btn;
                    e_minus <= !m_btn;
                end
            end
        end
    end

    always @(negedge sysclk) begin
        if (!reset) begin
            check("plus_step", int'(Plus_step), int'(e_plus));
            check("minus_step", int'(Minus_step), int'(e_minus));
            check("holding", int'(Holding), int'(e_hold));
            if (Plus_step) plus_q.push_back(cyc);
            if (Minus_step) minus_q.push_back(cyc);
            if (Holding) hold_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic clear_logs();
        plus_q.delete();
        minus_q.delete();
        hold_cnt = 0;
    endtask

    initial begin
        int k;
        int exp_edges[7];
        reset     = 1'b1;
        Plus_deb  = 1'b0;
        Minus_deb = 1'b0;
        #1;
        check("reset_plus", int'(Plus_step), 0);
        check("reset_minus", int'(Minus_step), 0);
        check("reset_hold", int'(Holding), 0);
        cycles(3);
        reset = 1'b0;

        // Single tap
        cycles(2);
        clear_logs();
        Plus_deb = 1'b1;
        k = cyc + 1;
        cycles(3);
        Plus_deb = 1'b0;
        cycles(4);
        check("tap_plus_count", plus_q.size(), 1);
        if (plus_q.size() > 0) check("tap_plus_edge", plus_q[0], k);
        check("tap_minus_count", minus_q.size(), 0);
        check("tap_hold_cycles", hold_cnt, 3);

        // Hold Minus for 30 cycles
        clear_logs();
        Minus_deb = 1'b1;
        k = cyc + 1;
        cycles(30);
        Minus_deb = 1'b0;
        cycles(10);
        exp_edges = '{0, 8, 12, 16, 20, 24, 28};
        check("hold_minus_count", minus_q.size(), 7);
        for (int i = 0; i < 7 && i < minus_q.size(); i++)
            check("hold_minus_edge", minus_q[i] - k, exp_edges[i]);
        check("hold_plus_count", plus_q.size(), 0);

        // Conflict
        cycles(2);
        clear_logs();
        Plus_deb = 1'b1;
        k = cyc + 1;
        cycles(5);
        Minus_deb = 1'b1;
        cycles(10);
        check("conf_plus_count", plus_q.size(), 1);
        Plus_deb = 1'b0;
        cycles(10);
        check("conf_minus_locked", minus_q.size(), 0);
        Minus_deb = 1'b0;
        cycles(2);
        Minus_deb = 1'b1;
        k = cyc + 1;
        cycles(2);
        Minus_deb = 1'b0;
        cycles(2);
        check("conf_repress_count", minus_q.size(), 1);
        if (minus_q.size() > 0) check("conf_repress_edge", minus_q[0], k);

        // Simultaneous press
        cycles(3);
        clear_logs();
        Plus_deb  = 1'b1;
        Minus_deb = 1'b1;
        cycles(12);
        Plus_deb  = 1'b0;
        Minus_deb = 1'b0;
        cycles(3);
        check("simul_strobes", plus_q.size() + minus_q.size(), 0);
        check("simul_hold", hold_cnt, 0);

        // Reset mid-hold (in REPEAT)
        Plus_deb = 1'b1;
        cycles(14);
        check("pre_reset_hold", int'(Holding), 1);
        #3 reset = 1'b1;
        #1;
        check("async_plus", int'(Plus_step), 0);
        check("async_minus", int'(Minus_step), 0);
        check("async_hold", int'(Holding), 0);
        cycles(2);
        reset = 1'b0;
        clear_logs();
        cycles(20);
        check("post_reset_strobes", plus_q.size(), 0);
        check("post_reset_hold", hold_cnt, 0);
        Plus_deb = 1'b0;
        cycles(2);
        Plus_deb = 1'b1;
        k = cyc + 1;
        cycles(2);
        Plus_deb = 1'b0;
        cycles(3);
        check("post_reset_repress", plus_q.size(), 1);
        if (plus_q.size() > 0) check("post_reset_edge", plus_q[0], k);

        // Release exactly on a REPEAT terminal count (edge k+12)
        cycles(2);
        clear_logs();
        Plus_deb = 1'b1;
        k = cyc + 1;
        cycles(12);
        Plus_deb = 1'b0;
        cycles(1);
        Plus_deb = 1'b1;
        cycles(1);
        Plus_deb = 1'b0;
        cycles(4);
        check("rtc_count", plus_q.size(), 3);
        if (plus_q.size() == 3) begin
            check("rtc_edge0", plus_q[0] - k, 0);
            check("rtc_edge1", plus_q[1] - k, 8);
            check("rtc_edge2", plus_q[2] - k, 13);
        end

        // Randomized levels, including long holds and occasional resets
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                Plus_deb  = 1'b0;
                Minus_deb = 1'b0;
            end else if (r < 6) begin
                Plus_deb  = 1'b1;
                Minus_deb = 1'b0;
            end else if (r < 8) begin
                Plus_deb  = 1'b0;
                Minus_deb = 1'b1;
            end else if (r < 9) begin
                Plus_deb  = 1'b1;
                Minus_deb = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                #2 reset = 1'b1;
                @(negedge sysclk);
                reset = 1'b0;
            end
            cycles(int'($urandom_range(1, 20)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/button_repeat.md
# button_repeat

Hold-to-repeat step generator between the button debouncer and the frequency-scale adjuster. It takes the two debounced button levels and emits single-cycle Plus/Minus step strobes: one strobe on press, then, while the button stays held, a strobe after an initial delay and then one every repeat period. Holding a button sweeps the waveform frequency scale without repeated presses. Conflicting presses are suppressed, so the adjuster never sees both directions at once.

## Interface
- INITIAL_DELAY, 50_000_000: sysclk cycles from the press strobe to the first repeat strobe; legal range is 2 or more.
- REPEAT_PERIOD, 10_000_000: sysclk cycles between successive repeat strobes; legal range is 2 or more.
- CNT_W, 27: repeat counter width; must satisfy 2^CNT_W > max(INITIAL_DELAY, REPEAT_PERIOD).
- sysclk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- Plus_deb  input  1  debounced Plus button level, already synchronous to sysclk.
- Minus_deb  input  1  debounced Minus button level, already synchronous to sysclk.
- Plus_step  output  1  registered one-cycle strobe; each pulse means one scale step up.
- Minus_step  output  1  registered one-cycle strobe; each pulse means one scale step down.
- Holding  output  1  registered; high while a single button is being held (states DELAY and REPEAT).

## Operation
- Registered state: FSM state, a direction bit (dir: 1 = Plus, 0 = Minus), an up-counter cnt[CNT_W-1:0], and the three outputs.
- States: WAIT_REL, IDLE, DELAY, REPEAT.
- **WAIT_REL** (this is the reset state):
  - If both inputs are low, go to IDLE.
  - Otherwise stay.
  - No strobes are emitted.
- **IDLE:**
  - Exactly one input high: set dir to that button, emit its strobe, clear cnt, go to DELAY.
  - Both inputs high: go to WAIT_REL with no strobe.
  - Both inputs low: stay.
- **DELAY:**
  - Other button high (whether or not the held one is still high): go to WAIT_REL.
  - Held button low and other low: go to IDLE.
  - Else, if cnt == INITIAL_DELAY-1: emit the dir strobe, clear cnt, go to REPEAT.
  - Else: increment cnt.
- **REPEAT:**
  - Same release and conflict rules as DELAY.
  - If cnt == REPEAT_PERIOD-1: emit the dir strobe and clear cnt.
  - Else: increment cnt.
- Priority within a cycle, highest first: conflict, then release, then terminal count. A strobe is never emitted in a cycle that leaves DELAY or REPEAT on release or conflict.
- Plus_step and Minus_step are mutually exclusive in every cycle.
- Each strobe is exactly one cycle wide.
- Holding = 1 exactly in cycles where the registered state is DELAY or REPEAT.
- cnt never wraps: it is cleared at terminal count and on every entry to DELAY.

## Timing
- Reset asserted (asynchronous): state = WAIT_REL, dir = 0, cnt = 0, Plus_step = 0, Minus_step = 0, Holding = 0.
- The reset values hold immediately and for as long as reset is high.
- After reset releases, a button already held produces no strobe until both buttons have been seen low for at least one edge. This applies equally to a reset asserted mid-hold.
- Let edge k be the first rising edge in IDLE at which exactly one input is sampled high.
  - Press strobe: high from edge k to edge k+1 (one-cycle latency from the input level).
  - First repeat strobe: asserted at edge k+INITIAL_DELAY.
  - Subsequent repeat strobes: asserted at edges k+INITIAL_DELAY+n·REPEAT_PERIOD, for n ≥ 1.
  - Holding: rises at edge k and falls at the edge where the release or conflict is sampled.
- Release and re-press:
  - A release sampled at edge m puts the FSM in IDLE after edge m.
  - A re-press sampled at edge m+1 strobes at m+1.
  - The minimum re-press spacing is therefore 2 cycles.

## Test plan
- Settings for all scenarios: INITIAL_DELAY = 8, REPEAT_PERIOD = 4.
- **Single tap:** reset, release it, wait 2 cycles, drive Plus_deb high for 3 cycles.
  - Required: exactly one Plus_step, in the cycle after the first high sample.
  - Required: Holding high for 3 cycles; Minus_step stays 0.
- **Hold:** Minus_deb high for 30 cycles with the press sampled at edge k.
  - Required: Minus_step pulses at k, k+8, k+12, k+16, k+20, k+24, k+28 (7 strobes).
  - Required: no strobe after the release.
- **Conflict:** hold Plus_deb, then raise Minus_deb at k+5.
  - Required: no further strobes.
  - Drop Plus_deb only: still no strobes.
  - Drop both, then press Minus: a Minus_step appears one cycle after its press.
- **Simultaneous press:** both inputs rise on the same edge from IDLE.
  - Required: no strobes, and Holding stays 0 throughout.
- **Reset mid-hold:** assert reset asynchronously during REPEAT while Plus_deb is held.
  - Required: all outputs are 0 immediately.
  - After reset release with Plus_deb still high: no strobes until Plus_deb goes low and is pressed again.
- **Release on terminal count:** drop Plus_deb at exactly the edge where cnt == 3 in REPEAT.
  - Required: no strobe on that edge, and the next state is IDLE.
